// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer.
// Contents:
//   FIB_W_DEF  default result/datapath width in bits
//   N_W_DEF    default width of the requested index n
//   FIB_MAX_N  largest index whose F(n) fits in FIB_W_DEF bits
//   state_e    sequencer FSM state encoding
package fib_pkg;

    localparam int FIB_W_DEF = 12;
    localparam int N_W_DEF   = 5;
    localparam int FIB_MAX_N = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fib_if.sv
// Request/response bundle between a requester and fib_sequencer.
// Signals:
//   start   request to compute F(n)
//   n       requested Fibonacci index
//   busy    sequencer is computing or presenting a result
//   done    one-cycle pulse marking a fresh result
//   result  F(n) mod 2^FIB_W, held until the next accepted request
//   ovf     true F(n) did not fit in FIB_W bits
// Modports: master drives the request, slave is the sequencer side.
interface fib_if
    import fib_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int N_W   = N_W_DEF
);

    logic             start;
    logic [N_W-1:0]   n;
    logic             busy;
    logic             done;
    logic [FIB_W-1:0] result;
    logic             ovf;

    modport master (
        output start,
        output n,
        input  busy,
        input  done,
        input  result,
        input  ovf
    );

    modport slave (
        input  start,
        input  n,
        output busy,
        output done,
        output result,
        output ovf
    );

endinterface

// File: rtl/fib_datapath.sv
// prev/cur Fibonacci pair with wrap-around adder and sticky overflow tags.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       start a new sequence: prev=F(0)=0, cur=F(1)=1, tags cleared
//   step       advance one index: prev<=cur, cur<=cur+prev
//   prev       current F(k) mod 2^FIB_W
//   prev_ovf   set when the true F(k) exceeded the register width
module fib_datapath
    import fib_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [FIB_W-1:0] prev,
    output logic             prev_ovf
);

    logic [FIB_W-1:0] prev_q, prev_d;
    logic [FIB_W-1:0] cur_q, cur_d;
    logic             prev_ovf_q, prev_ovf_d;
    logic             cur_ovf_q, cur_ovf_d;
    logic [FIB_W:0]   sum;

    // One extra bit captures the carry out of the wrapping add.
    assign sum = {1'b0, cur_q} + {1'b0, prev_q};

    // Each tag follows its value through the pair; once any term has
    // overflowed, every later term is also too large, so the tag is sticky.
    always_comb begin
        prev_d     = prev_q;
        cur_d      = cur_q;
        prev_ovf_d = prev_ovf_q;
        cur_ovf_d  = cur_ovf_q;
        if (load) begin
            prev_d     = '0;
            cur_d      = FIB_W'(1);
            prev_ovf_d = 1'b0;
            cur_ovf_d  = 1'b0;
        end else if (step) begin
            prev_d     = cur_q;
            cur_d      = sum[FIB_W-1:0];
            prev_ovf_d = cur_ovf_q;
            cur_ovf_d  = cur_ovf_q | prev_ovf_q | sum[FIB_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            cur_q      <= FIB_W'(1);
            prev_ovf_q <= 1'b0;
            cur_ovf_q  <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            prev_ovf_q <= prev_ovf_d;
            cur_ovf_q  <= cur_ovf_d;
        end
    end

    assign prev     = prev_q;
    assign prev_ovf = prev_ovf_q;

endmodule

// File: rtl/fib_sequencer.sv
// Computes F(n) iteratively, one datapath step per clock.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        fib_if slave: start/n request in, busy/done/result/ovf out
// A request is accepted only in IDLE; done pulses n+1 cycles after the
// accepting edge and the FSM is back in IDLE one cycle later.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int N_W   = N_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    fib_if.slave  bus
);

    state_e           state_q, state_d;
    logic [N_W-1:0]   cnt_q, cnt_d;
    logic             load;
    logic             step;
    logic [FIB_W-1:0] prev;
    logic             prev_ovf;

    fib_datapath #(
        .FIB_W (FIB_W)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .prev     (prev),
        .prev_ovf (prev_ovf)
    );

    // cnt counts remaining steps; the RUN cycle that finds it at zero is
    // the extra cycle that moves to DONE without touching the datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.n;
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    step  = 1'b1;
                    cnt_d = cnt_q - N_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = prev;
    assign bus.ovf    = prev_ovf;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed self-checking bench for fib_sequencer (FIB_W=12, N_W=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fib_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fib_if #(.FIB_W(12), .N_W(5)) bus ();

    fib_sequencer #(
        .FIB_W (12),
        .N_W   (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one start pulse for index nv, then check latency, done pulse
    // width, result/ovf at done and that the result is held afterwards.
    task automatic run_n(input logic [4:0] nv, input int exp_res, input logic exp_ovf);
        int cyc;
        bus.start = 1'b1;
        bus.n     = nv;
        tick();
        bus.start = 1'b0;
        bus.n     = 5'd0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        chk($sformatf("n%0d_latency", nv), 32'(cyc), 32'(int'(nv) + 1));
        chk($sformatf("n%0d_result", nv), 32'(bus.result), 32'(exp_res));
        chk($sformatf("n%0d_ovf", nv), 32'(bus.ovf), 32'(exp_ovf));
        chk($sformatf("n%0d_busy_at_done", nv), 32'(bus.busy), 32'd1);
        tick();
        chk($sformatf("n%0d_done_single", nv), 32'(bus.done), 32'd0);
        chk($sformatf("n%0d_idle_busy", nv), 32'(bus.busy), 32'd0);
        tick();
        chk($sformatf("n%0d_result_held", nv), 32'(bus.result), 32'(exp_res));
        chk($sformatf("n%0d_ovf_held", nv), 32'(bus.ovf), 32'(exp_ovf));
    endtask

    initial begin
        int done_cnt;
        int done_at;
        int res_at;
        int last_done;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.n     = 5'd0;
        tick();
        tick();

        // Reset state.
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);

        // Reset wins over start on the same edge.
        bus.start = 1'b1;
        bus.n     = 5'd4;
        tick();
        chk("rst_prio_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();
        chk("idle_hold_busy", 32'(bus.busy), 32'd0);

        // Single requests, hand-computed F(n) mod 4096.
        run_n(5'd10, 55, 1'b0);
        run_n(5'd0, 0, 1'b0);
        run_n(5'd1, 1, 1'b0);
        run_n(5'd18, 2584, 1'b0);
        run_n(5'd19, 85, 1'b1);
        run_n(5'd31, 2781, 1'b1);

        // Start (with a different n) pulsed during RUN must be ignored.
        bus.start = 1'b1;
        bus.n     = 5'd5;
        tick();
        bus.start = 1'b0;
        done_cnt  = 0;
        done_at   = -1;
        res_at    = -1;
        for (int s = 0; s < 16; s++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = s;
                    res_at  = int'(bus.result);
                end
            end
            if (s == 2) begin
                bus.start = 1'b1;
                bus.n     = 5'd2;
            end
            if (s == 3) begin
                bus.start = 1'b0;
            end
            tick();
        end
        chk("ign_done_count", 32'(done_cnt), 32'd1);
        chk("ign_latency", 32'(done_at), 32'd6);
        chk("ign_result", 32'(res_at), 32'd5);
        chk("ign_idle_after", 32'(bus.busy), 32'd0);

        // Reset during RUN aborts without a done pulse.
        bus.start = 1'b1;
        bus.n     = 5'd12;
        tick();
        bus.start = 1'b0;
        done_cnt  = 0;
        for (int s = 0; s < 3; s++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        chk("abort_running", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        for (int s = 0; s < 20; s++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Start held high: done every 6 cycles, one IDLE cycle between runs.
        bus.start = 1'b1;
        bus.n     = 5'd3;
        tick();
        done_cnt  = 0;
        last_done = -1;
        for (int s = 0; s < 25; s++) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                chk($sformatf("b2b_result_%0d", done_cnt), 32'(bus.result), 32'd2);
                if (last_done < 0) begin
                    chk("b2b_first_latency", 32'(s), 32'd4);
                end else begin
                    chk($sformatf("b2b_period_%0d", done_cnt), 32'(s - last_done), 32'd6);
                end
                last_done = s;
            end
            if (s == 5) begin
                chk("b2b_idle_gap", 32'(bus.busy), 32'd0);
            end
            tick();
        end
        chk("b2b_done_count", 32'(done_cnt), 32'd4);
        bus.start = 1'b0;
        for (int s = 0; s < 8; s++) tick();
        chk("b2b_final_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
